multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Multi-cycle sequencer for the iterative multiply/divide unit in the simple processor. It detects R-type `mul`/`div` instructions and freezes the PC through `stall` while the unit is busy. It latches the operands, issues a one-cycle start pulse, waits for completion or a timeout, and then drives a one-cycle register writeback. On exception, the writeback goes to `$rstatus` (r30) instead of `rd`.

## Interface
- `TIMEOUT`, default 40: maximum WAIT cycles before the operation is aborted as an exception. Must be ≥ 2.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  5  opcode of the instruction currently in decode.
- `ALUop`  in  5  ALU op field of that instruction.
- `rd`  in  5  destination register field.
- `op_a`, `op_b`  in  32 each  register-file read data for rs and rt.
- `md_result`  in  32  result from the multdiv unit.
- `md_exception`  in  1  multdiv exception flag; valid only with `md_ready`.
- `md_ready`  in  1  multdiv completion strobe.
- `md_a`, `md_b`  out  32 each  latched operands; held stable from ISSUE through WB.
- `md_mult`, `md_div`  out  1 each  one-cycle start pulses.
- `stall`  out  1  freeze PC and inhibit normal register write.
- `wb_en`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  5  writeback target register.
- `wb_data`  out  32  writeback value.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- Decode:
  - `is_md` = (`opcode`==5'b00000) and (`ALUop`==5'b00110 mul or 5'b00111 div).
  - Decode is evaluated only in IDLE.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - `stall` = `is_md` (combinational), so the PC does not advance past the instruction.
  - If `is_md`: latch `op_a`/`op_b`/`rd`/op-type, then go to ISSUE.
- ISSUE:
  - `stall`=1.
  - `md_mult` or `md_div` = 1 according to the latched type; exactly one of them, for exactly one cycle.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - `stall`=1; the counter increments each cycle.
  - If `md_ready`: latch `md_result` and `md_exception`, then go to WB.
  - Else if counter == `TIMEOUT`-1: set exception, then go to WB.
  - If `md_ready` arrives in the timeout cycle, `md_ready` wins.
- WB:
  - `stall`=0, so the PC advances at the end of this cycle.
  - `wb_en`=1 unless there is no exception and the latched `rd`==0; in that case `wb_en`=0 (r0 is never written).
  - Normal result: `wb_rd`=latched `rd`, `wb_data`=result.
  - Exception (unit-flagged or timeout): `wb_rd`=30, `wb_data`=4 for mul or 5 for div.
  - Go to IDLE. The decode inputs are ignored in WB, so the same instruction cannot retrigger.
- Inputs outside WAIT: `md_ready`/`md_exception` in IDLE, ISSUE and WB are ignored.
- Top-level wiring: register write enable = (`Rwe` and not `stall` and not `is_md`-in-WB) or `wb_en`. When `wb_en` is high, `wb_rd`/`wb_data` override the normal write path.
- Counter width: $clog2(`TIMEOUT`+1) bits. The counter never wraps because it is cleared in ISSUE.

## Timing
- Reset (async, `reset_n`=0):
  - State goes to IDLE immediately.
  - All outputs are 0: `md_a`, `md_b`, `wb_rd`, `wb_data`, pulses, `stall`, `busy`.
  - Latches and the counter are cleared.
  - Any in-flight operation is discarded, and nothing is written back.
- Release: the first rising edge with `reset_n`=1 may accept an instruction.
- Cycle map (`is_md` seen in IDLE at cycle T0):
  - T0: IDLE, `stall`=1.
  - T1: ISSUE, start pulse.
  - T2..Tn: WAIT.
  - Tn+1: WB with `wb_en`.
- Best case is `md_ready` at T2, giving WB at T3 and 3 stall cycles. Total stall = 3 + (WAIT cycles − 1).
- Timeout: `md_ready` never arrives, so there are exactly `TIMEOUT` WAIT cycles and then WB with the exception.
- Back-to-back md instructions: WB at Tk, IDLE detects the next instruction at Tk+1. There is no bubble beyond one IDLE cycle.
- `busy` is registered state; `stall` is combinational in IDLE and registered-state-derived otherwise.

## Test plan
- Reset mid-WAIT: pulse `reset_n` low with the unit not ready → state IDLE, all outputs 0, no `wb_en` afterwards.
- mul r5 = 7×6: `md_ready` 4 cycles after the start pulse with `md_result`=42 →
  - exactly one `md_mult` pulse;
  - `md_a`=7, `md_b`=6;
  - `stall` high through WAIT;
  - WB with `wb_rd`=5, `wb_data`=42, one-cycle `wb_en`.
- div with `md_exception`=1 at ready → `wb_rd`=30, `wb_data`=5, `md_div` pulsed once.
- mul with `TIMEOUT`=8 and `md_ready` never asserted →
  - exactly 8 WAIT cycles;
  - `wb_rd`=30, `wb_data`=4;
  - `md_ready` arriving later in IDLE is ignored.
- mul to r0 with a valid result 99 → `wb_en` stays 0, and `stall` drops in WB.
- Back-to-back mul then div, plus an add in between →
  - add: no stall;
  - each md op gets its own start pulse;
  - writebacks are in program order;
  - `md_ready` arriving on the timeout cycle yields the normal result, not the exception.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
// Decode, operand, multdiv-handshake and writeback signals shared between the
// processor pipeline and the multiply/divide sequencer.
interface multdiv_sequencer_if;
  logic [4:0]  opcode;
  logic [4:0]  ALUop;
  logic [4:0]  rd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;

  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_mult;
  logic        md_div;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  modport master (
    output opcode, ALUop, rd, op_a, op_b, md_result, md_exception, md_ready,
    input  md_a, md_b, md_mult, md_div, stall, wb_en, wb_rd, wb_data, busy
  );

  modport slave (
    input  opcode, ALUop, rd, op_a, op_b, md_result, md_exception, md_ready,
    output md_a, md_b, md_mult, md_div, stall, wb_en, wb_rd, wb_data, busy
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multi-cycle sequencer for the iterative mul/div unit: stalls the PC, issues a
// start pulse, waits for completion or timeout, then writes back rd or $rstatus.
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic          clock,
  input  logic          reset_n,
  multdiv_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [4:0]  OPC_RTYPE = 5'b00000;
  localparam logic [4:0]  ALU_MUL   = 5'b00110;
  localparam logic [4:0]  ALU_DIV   = 5'b00111;
  localparam logic [4:0]  RSTATUS   = 5'd30;
  localparam logic [31:0] EXC_MUL   = 32'd4;
  localparam logic [31:0] EXC_DIV   = 32'd5;

  logic [1:0]    state;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [4:0]    rd_q;
  logic          div_q;
  logic [31:0]   res_q;
  logic          exc_q;
  logic [CW-1:0] cnt;

  logic is_md;
  logic is_div;

  logic        mult_pulse;
  logic        div_pulse;
  logic        stall_c;
  logic        wb_en_c;
  logic [4:0]  wb_rd_c;
  logic [31:0] wb_data_c;

  assign is_md  = (bus.opcode == OPC_RTYPE) &&
                  ((bus.ALUop == ALU_MUL) || (bus.ALUop == ALU_DIV));
  assign is_div = (bus.ALUop == ALU_DIV);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      div_q <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_md) begin
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            rd_q  <= bus.rd;
            div_q <= is_div;
            res_q <= '0;
            exc_q <= 1'b0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          // A completion in the final wait cycle takes priority over the timeout.
          if (bus.md_ready) begin
            res_q <= bus.md_result;
            exc_q <= bus.md_exception;
            state <= S_WB;
          end else if (cnt == LAST_WAIT) begin
            exc_q <= 1'b1;
            state <= S_WB;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mult_pulse = 1'b0;
    div_pulse  = 1'b0;
    stall_c    = 1'b0;
    wb_en_c    = 1'b0;
    wb_rd_c    = '0;
    wb_data_c  = '0;
    case (state)
      S_IDLE: begin
        stall_c = is_md;
      end
      S_ISSUE: begin
        stall_c    = 1'b1;
        mult_pulse = !div_q;
        div_pulse  = div_q;
      end
      S_WAIT: begin
        stall_c = 1'b1;
      end
      S_WB: begin
        // r0 is never written, but an exception always reaches $rstatus.
        wb_en_c   = exc_q || (rd_q != '0);
        wb_rd_c   = exc_q ? RSTATUS : rd_q;
        wb_data_c = exc_q ? (div_q ? EXC_DIV : EXC_MUL) : res_q;
      end
      default: begin
        stall_c = 1'b0;
      end
    endcase
  end

  assign bus.md_a    = a_q;
  assign bus.md_b    = b_q;
  assign bus.md_mult = mult_pulse;
  assign bus.md_div  = div_pulse;
  assign bus.stall   = stall_c;
  assign bus.wb_en   = wb_en_c;
  assign bus.wb_rd   = wb_rd_c;
  assign bus.wb_data = wb_data_c;
  assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: table vectors, hand-written corner
// sequences and randomized operations against a transaction-level model.
module tb_multdiv_sequencer;

  localparam int T = 8;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  multdiv_sequencer_if bus ();

  multdiv_sequencer #(.TIMEOUT(T)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        dv;
    logic [4:0]  r;
    logic [31:0] a;
    logic [31:0] b;
    int          dly;     // WAIT cycle (1-based) in which md_ready comes; 0 = never
    logic        ux;
    logic        en;
    logic [4:0]  erd;
    logic [31:0] edata;
    int          estall;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] unit_res(input logic dv, input logic [31:0] a, input logic [31:0] b);
    if (dv) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    return a * b;
  endfunction

  task automatic set_decode(input logic [4:0] opc, input logic [4:0] alu, input logic [4:0] r,
                            input logic [31:0] a, input logic [31:0] b);
    bus.opcode = opc;
    bus.ALUop  = alu;
    bus.rd     = r;
    bus.op_a   = a;
    bus.op_b   = b;
  endtask

  // Starts at a negedge with the DUT idle, holds the instruction in decode until
  // writeback (as a frozen PC would) and returns at the negedge after WB.
  task automatic run_op(input string tag, input logic dv, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] b, input int dly, input logic ux,
                        input logic en, input logic [4:0] erd, input logic [31:0] edata,
                        input int estall);
    int n_stall = 0, n_mult = 0, n_div = 0, n_wb = 0, n_wait = 0, p = -1;
    logic first_stall = 1'b0, wb_seen = 1'b0;
    logic [4:0]  got_rd = '0;
    logic [31:0] got_data = '0, wa = '0, wbv = '0;
    logic [31:0] res;
    res = unit_res(dv, a, b);
    set_decode(5'b00000, dv ? 5'b00111 : 5'b00110, r, a, b);
    for (int c = 0; c < T + 12; c++) begin
      if (p >= 0 && dly > 0 && c == p + dly) begin
        bus.md_ready = 1'b1;
        bus.md_result = res;
        bus.md_exception = ux;
      end else begin
        bus.md_ready = 1'b0;
        bus.md_result = $urandom;
        bus.md_exception = 1'($urandom);
      end
      #1;
      if (c == 0) first_stall = bus.stall;
      if (bus.stall) n_stall++;
      if (bus.md_mult) begin n_mult++; if (p < 0) p = c; end
      if (bus.md_div)  begin n_div++;  if (p < 0) p = c; end
      if (bus.busy && bus.stall && p >= 0 && c > p) n_wait++;
      if (bus.wb_en) begin n_wb++; got_rd = bus.wb_rd; got_data = bus.wb_data; end
      if (bus.busy && !bus.stall) begin wb_seen = 1'b1; wa = bus.md_a; wbv = bus.md_b; end
      @(negedge clock);
      if (wb_seen) break;
    end
    bus.md_ready = 1'b0;
    chk({tag, " wb_reached"}, 32'(wb_seen), 32'd1);
    chk({tag, " stall_at_decode"}, 32'(first_stall), 32'd1);
    chk({tag, " pulse_cycle"}, 32'(p), 32'd1);
    chk({tag, " mult_pulses"}, 32'(n_mult), dv ? 32'd0 : 32'd1);
    chk({tag, " div_pulses"}, 32'(n_div), dv ? 32'd1 : 32'd0);
    chk({tag, " stall_cycles"}, 32'(n_stall), 32'(estall));
    chk({tag, " wait_cycles"}, 32'(n_wait), 32'(estall - 2));
    chk({tag, " md_a"}, wa, a);
    chk({tag, " md_b"}, wbv, b);
    chk({tag, " wb_count"}, 32'(n_wb), en ? 32'd1 : 32'd0);
    if (en) begin
      chk({tag, " wb_rd"}, 32'(got_rd), 32'(erd));
      chk({tag, " wb_data"}, got_data, edata);
    end
  endtask

  // Expected outcome derived directly from the operation rules.
  task automatic run_model_op(input string tag, input logic dv, input logic [4:0] r,
                              input logic [31:0] a, input logic [31:0] b, input int dly,
                              input logic ux);
    logic timed_out, exc;
    int   waits;
    timed_out = (dly == 0) || (dly > T);
    exc   = timed_out ? 1'b1 : ux;
    waits = timed_out ? T : dly;
    run_op(tag, dv, r, a, b, dly, ux, exc || (r != 5'd0), exc ? 5'd30 : r,
           exc ? (dv ? 32'd5 : 32'd4) : unit_res(dv, a, b), waits + 2);
  endtask

  task automatic idle_cycles(input string tag, input int n, input logic rdy);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      bus.md_ready = rdy;
      bus.md_exception = rdy;
      #1;
      if (bus.stall || bus.busy || bus.wb_en || bus.md_mult || bus.md_div) bad++;
      @(negedge clock);
    end
    bus.md_ready = 1'b0;
    bus.md_exception = 1'b0;
    chk({tag, " idle_activity"}, 32'(bad), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 5'd5,  32'd7,        32'd6,       4, 1'b0, 1'b1, 5'd5,  32'd42,        6};
    tbl[1] = '{1'b1, 5'd3,  32'd100,      32'd7,       1, 1'b0, 1'b1, 5'd3,  32'd14,        3};
    tbl[2] = '{1'b1, 5'd9,  32'd10,       32'd0,       2, 1'b1, 1'b1, 5'd30, 32'd5,         4};
    tbl[3] = '{1'b0, 5'd7,  32'd3,        32'd5,       0, 1'b0, 1'b1, 5'd30, 32'd4,        10};
    tbl[4] = '{1'b0, 5'd0,  32'd9,        32'd11,      3, 1'b0, 1'b0, 5'd0,  32'd0,         5};
    tbl[5] = '{1'b0, 5'd12, 32'd1000,     32'd1000,    8, 1'b0, 1'b1, 5'd12, 32'd1000000,  10};
    tbl[6] = '{1'b0, 5'd0,  32'd2,        32'd2,       0, 1'b0, 1'b1, 5'd30, 32'd4,        10};
    tbl[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 32'd16,      5, 1'b0, 1'b1, 5'd31, 32'h0FFFFFFF,  7};
    tbl[8] = '{1'b0, 5'd1,  32'h00010000, 32'h00010000,1, 1'b0, 1'b1, 5'd1,  32'd0,         3};
    tbl[9] = '{1'b0, 5'd4,  32'd5,        32'd5,       2, 1'b1, 1'b1, 5'd30, 32'd4,         4};

    reset_n = 1'b0;
    set_decode(5'b00000, 5'b00000, 5'd0, '0, '0);
    bus.md_result = '0;
    bus.md_exception = 1'b0;
    bus.md_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset md_a", bus.md_a, 32'd0);
    chk("reset md_b", bus.md_b, 32'd0);
    chk("reset pulses", {30'd0, bus.md_mult, bus.md_div}, 32'd0);
    chk("reset wb", {26'd0, bus.wb_en, bus.wb_rd}, 32'd0);
    chk("reset wb_data", bus.wb_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table vectors run back to back: each starts in the cycle right after WB.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].dv, tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].dly,
             tbl[i].ux, tbl[i].en, tbl[i].erd, tbl[i].edata, tbl[i].estall);

    // Late md_ready in IDLE after a timeout, and non-md decodes, must do nothing.
    run_op("timeout", 1'b0, 5'd8, 32'd3, 32'd3, 0, 1'b0, 1'b1, 5'd30, 32'd4, T + 2);
    set_decode(5'b00000, 5'b00000, 5'd2, 32'd1, 32'd2);
    idle_cycles("late_ready", 2, 1'b1);
    set_decode(5'b00101, 5'b00110, 5'd2, 32'd1, 32'd2);
    idle_cycles("non_rtype", 2, 1'b0);

    // mul, add, div in program order.
    run_op("seq_mul", 1'b0, 5'd10, 32'd12, 32'd12, 2, 1'b0, 1'b1, 5'd10, 32'd144, 4);
    set_decode(5'b00000, 5'b00000, 5'd11, 32'd1, 32'd1);
    idle_cycles("seq_add", 1, 1'b0);
    run_op("seq_div", 1'b1, 5'd11, 32'd144, 32'd12, T, 1'b0, 1'b1, 5'd11, 32'd12, T + 2);

    // Reset in the middle of WAIT.
    set_decode(5'b00000, 5'b00110, 5'd6, 32'd21, 32'd2);
    repeat (4) @(negedge clock);
    #1;
    chk("pre_reset in_wait", {30'd0, bus.busy, bus.stall}, 32'd3);
    reset_n = 1'b0;
    set_decode(5'b00000, 5'b00000, 5'd0, '0, '0);
    #1;
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset stall", 32'(bus.stall), 32'd0);
    chk("midreset md_a", bus.md_a, 32'd0);
    chk("midreset wb_en", 32'(bus.wb_en), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_cycles("post_reset", T + 4, 1'b1);

    for (int i = 0; i < 30; i++) begin
      logic dv;
      logic [31:0] a, b;
      dv = 1'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_model_op($sformatf("rnd%0d", i), dv, 5'($urandom_range(0, 31)), a, b,
                   $urandom_range(0, T + 2), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        set_decode(5'b00000, 5'b00001, 5'd3, $urandom, $urandom);
        idle_cycles($sformatf("rnd%0d gap", i), 1, 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
